agu_ctrl: RTL and testbench

AGU_CTRL -- requirements
Module: agu_ctrl

---
 rtl/agu_ctrl_pkg.sv | 6 +
 rtl/agu_ctrl_se9.sv | 9 +
 rtl/agu_ctrl.sv | 78 +++++++
 tb/tb_agu_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/agu_ctrl_pkg.sv
// agu_ctrl_pkg: shared state encoding and sizing for the D-type address generation unit
package agu_ctrl_pkg;
  localparam int AW = 64;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/agu_ctrl_se9.sv
// se9: sign-extends the 9-bit LDUR/STUR immediate to the full address width
module se9
  import agu_ctrl_pkg::*;
(
  input  logic [8:0]    i_imm,
  output logic [AW-1:0] o_ext
);
  assign o_ext = {{(AW-9){i_imm[8]}}, i_imm};
endmodule

// File: rtl/agu_ctrl.sv
// agu_ctrl: computes base+imm9, checks alignment and sequences one memory request/response
module agu_ctrl
  import agu_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_load,
  input  logic [AW-1:0] base,
  input  logic [8:0]    imm9,
  input  logic [AW-1:0] wdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [AW-1:0] mem_wdata,
  input  logic          mem_rsp_valid,
  input  logic [AW-1:0] mem_rdata,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr, r_wdata, r_rdata, w_ext, w_addr;
  logic r_we, r_err, w_mis, w_timeout;
  se9 u_se9 (.i_imm(imm9), .o_ext(w_ext));
  assign w_addr = base + w_ext;
  assign w_mis = ALIGN_CHK && (w_addr[2:0] != 3'd0);
  assign w_timeout = r_cnt == LAST;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? (w_mis ? S_DONE : S_REQ) : S_IDLE;
      S_REQ:   w_next = mem_req_ready ? (r_we ? S_DONE : S_WAIT) : S_REQ;
      S_WAIT:  w_next = (mem_rsp_valid || w_timeout) ? S_DONE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  // a response in the timeout cycle takes priority over the timeout fault
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && start) begin
        r_addr  <= w_addr;
        r_we    <= ~is_load;
        r_wdata <= wdata;
        r_err   <= w_mis;
        r_rdata <= '0;
      end
      if (r_state == S_WAIT && mem_rsp_valid) r_rdata <= mem_rdata;
      else if (r_state == S_WAIT && w_timeout) r_err <= 1'b1;
    end
  end
  assign mem_req_valid = r_state == S_REQ;
  assign mem_addr      = r_addr;
  assign mem_we        = r_we;
  assign mem_wdata     = r_wdata;
  assign done          = r_state == S_DONE;
  assign err           = done & r_err;
  assign rdata         = done ? r_rdata : '0;
  assign stall         = (r_state == S_IDLE && start) || r_state == S_REQ || r_state == S_WAIT;
endmodule

// File: tb/tb_agu_ctrl.sv
// tb_agu_ctrl: directed scenarios plus randomized ops against a cycle-timing reference model
module tb_agu_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset, start, is_load, mem_req_ready, mem_rsp_valid;
  logic [63:0] base, wdata, mem_rdata;
  logic [8:0] imm9;
  logic mem_req_valid, mem_we, stall, done, err;
  logic [63:0] mem_addr, mem_wdata, rdata;
  int errors = 0, checks = 0;

  agu_ctrl #(.TIMEOUT(TO), .ALIGN_CHK(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .base(base), .imm9(imm9),
    .wdata(wdata), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .stall(stall), .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_addr(input logic [63:0] b, input logic [8:0] i);
    longint off;
    off = i[8] ? longint'(i) - 512 : longint'(i);
    return b + 64'(off);
  endfunction

  task automatic test_reset();
    @(negedge clk); reset = 1; start = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    @(negedge clk); reset = 0; #1;
    checks++; if ({mem_req_valid, mem_we, done, err, stall} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b exp 00000", {mem_req_valid, mem_we, done, err, stall}); end
    checks++; if ({mem_addr, mem_wdata, rdata} !== 192'b0) begin errors++; $display("FAIL reset_data: got %h %h %h exp 0", mem_addr, mem_wdata, rdata); end
  endtask

  task automatic test_store();
    logic [63:0] w;
    w = {$urandom, $urandom};
    @(negedge clk); start = 1; is_load = 0; base = 64'h1000; imm9 = 9'h1F8; wdata = w; mem_req_ready = 1; #1;
    checks++; if ({stall, mem_req_valid} !== 2'b10) begin errors++; $display("FAIL store_c0: got %b exp 10", {stall, mem_req_valid}); end
    @(negedge clk); start = 0; #1;
    checks++; if ({mem_req_valid, mem_we, done, mem_addr, mem_wdata} !== {3'b110, 64'hFF8, w}) begin errors++; $display("FAIL store_req: got %b %h %h exp 110 ff8 %h", {mem_req_valid, mem_we, done}, mem_addr, mem_wdata, w); end
    @(negedge clk); #1;
    checks++; if ({done, err, stall, mem_req_valid} !== 4'b1000) begin errors++; $display("FAIL store_done: got %b exp 1000", {done, err, stall, mem_req_valid}); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL store_after: done got %b exp 0", done); end
  endtask

  task automatic test_load_handshake();
    @(negedge clk); start = 1; is_load = 1; base = 64'h2000; imm9 = 9'h010; mem_req_ready = 0; mem_rsp_valid = 0; #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 0; base = {$urandom, $urandom}; mem_req_ready = (c == 4);
      mem_rsp_valid = (c < 4); mem_rdata = {$urandom, $urandom}; #1;
      checks++; if ({mem_req_valid, stall, mem_we, mem_addr} !== {3'b110, 64'h2010}) begin errors++; $display("FAIL load_req c%0d: got %b %h exp 110 2010", c, {mem_req_valid, stall, mem_we}, mem_addr); end
    end
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk); mem_req_ready = 0; mem_rsp_valid = (c == 7);
      mem_rdata = (c == 7) ? 64'hDEADBEEF : {$urandom, $urandom}; #1;
      checks++; if ({mem_req_valid, stall, done, mem_addr} !== {3'b010, 64'h2010}) begin errors++; $display("FAIL load_wait c%0d: got %b %h exp 010 2010", c, {mem_req_valid, stall, done}, mem_addr); end
    end
    @(negedge clk); mem_rsp_valid = 0; #1;
    checks++; if ({done, err, stall, rdata} !== {3'b100, 64'hDEADBEEF}) begin errors++; $display("FAIL load_done: got %b %h exp 100 deadbeef", {done, err, stall}, rdata); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); start = 1; is_load = 1; base = 64'h3; imm9 = 9'h001; mem_req_ready = 1; #1;
    checks++; if ({stall, mem_req_valid} !== 2'b10) begin errors++; $display("FAIL mis_c0: got %b exp 10", {stall, mem_req_valid}); end
    @(negedge clk); start = 0; #1;
    checks++; if ({done, err, mem_req_valid, stall, rdata} !== {4'b1100, 64'h0}) begin errors++; $display("FAIL mis_done: got %b %h exp 1100 0", {done, err, mem_req_valid, stall}, rdata); end
    @(negedge clk); #1;
    checks++; if ({done, mem_req_valid} !== 2'b00) begin errors++; $display("FAIL mis_after: got %b exp 00", {done, mem_req_valid}); end
  endtask

  task automatic test_timeout();
    logic [63:0] v;
    for (int k = 0; k < 2; k++) begin
      v = {$urandom, $urandom};
      @(negedge clk); start = 1; is_load = 1; base = {$urandom, $urandom} & ~64'h7; imm9 = 9'h0;
      mem_req_ready = 1; mem_rsp_valid = 0; #1;
      @(negedge clk); start = 0; #1;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL to_req k%0d: got %b exp 1", k, mem_req_valid); end
      for (int c = 2; c < 2 + TO; c++) begin
        @(negedge clk); mem_rsp_valid = (k == 1 && c == TO + 1);
        mem_rdata = (c == TO + 1) ? v : {$urandom, $urandom}; #1;
        checks++; if ({done, stall, mem_req_valid} !== 3'b010) begin errors++; $display("FAIL to_wait k%0d c%0d: got %b exp 010", k, c, {done, stall, mem_req_valid}); end
      end
      @(negedge clk); mem_rsp_valid = 0; #1;
      checks++; if ({done, err, rdata} !== {1'b1, k == 0, (k == 1) ? v : 64'h0}) begin errors++; $display("FAIL to_done k%0d: got %b %b %h", k, done, err, rdata); end
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk); start = 1; is_load = 0; base = 64'h100; imm9 = 9'h0; mem_req_ready = 0; #1;
    @(negedge clk); start = 0; #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL abort_req: got %b exp 1", mem_req_valid); end
    @(negedge clk); reset = 1; #1;
    @(negedge clk); reset = 0; #1;
    checks++; if ({mem_req_valid, done, stall, mem_we, mem_addr} !== 68'h0) begin errors++; $display("FAIL abort_req_rst: got %b %h exp 0", {mem_req_valid, done, stall, mem_we}, mem_addr); end
    @(negedge clk); start = 1; is_load = 1; base = 64'h200; mem_req_ready = 1; #1;
    @(negedge clk); start = 0; #1;
    @(negedge clk); #1;
    checks++; if ({mem_req_valid, stall} !== 2'b01) begin errors++; $display("FAIL abort_wait: got %b exp 01", {mem_req_valid, stall}); end
    @(negedge clk); reset = 1; mem_rsp_valid = 1; mem_rdata = {$urandom, $urandom}; #1;
    @(negedge clk); reset = 0; mem_rsp_valid = 0; #1;
    checks++; if ({mem_req_valid, done, err, stall, mem_we, mem_addr, rdata} !== 133'h0) begin errors++; $display("FAIL abort_wait_rst: got %b %h %h exp 0", {mem_req_valid, done, err, stall, mem_we}, mem_addr, rdata); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone c%0d: got %b exp 0", c, done); end
    end
    @(negedge clk); start = 1; is_load = 0; base = 64'h300; imm9 = 9'h008; wdata = 64'hA5A5; mem_req_ready = 1; #1;
    @(negedge clk); start = 0; #1;
    checks++; if ({mem_req_valid, mem_addr, mem_wdata} !== {1'b1, 64'h308, 64'hA5A5}) begin errors++; $display("FAIL abort_new_req: got %b %h %h exp 1 308 a5a5", mem_req_valid, mem_addr, mem_wdata); end
    @(negedge clk); #1;
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL abort_new_done: got %b exp 10", {done, err}); end
  endtask

  task automatic test_wrap_hold();
    @(negedge clk); start = 1; is_load = 0; base = 64'hFFFF_FFFF_FFFF_FFF8; imm9 = 9'h008; mem_req_ready = 1; #1;
    @(negedge clk); #1;
    checks++; if ({mem_req_valid, stall, mem_addr} !== {2'b11, 64'h0}) begin errors++; $display("FAIL wrap_req: got %b %h exp 11 0", {mem_req_valid, stall}, mem_addr); end
    @(negedge clk); #1;
    checks++; if ({done, err, stall} !== 3'b100) begin errors++; $display("FAIL wrap_done: got %b exp 100", {done, err, stall}); end
    @(negedge clk); start = 0; #1;
    checks++; if ({mem_req_valid, done, stall} !== 3'b000) begin errors++; $display("FAIL hold_reaccept: got %b exp 000", {mem_req_valid, done, stall}); end
    @(negedge clk); #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_after: got %b exp 0", mem_req_valid); end
  endtask

  task automatic test_random();
    logic ld, mis, inw, exp_err;
    logic [63:0] b, a, rv, wv, exp_rd;
    logic [8:0] i;
    int rd, wd, donec;
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom); b = {$urandom, $urandom}; i = 9'($urandom);
      if ($urandom_range(0, 2) != 0) begin b[2:0] = 3'b0; i[2:0] = 3'b0; end
      a = ref_addr(b, i); mis = a[2:0] != 3'b0;
      rd = $urandom_range(0, 3);
      wd = ($urandom_range(0, 3) == 0) ? TO : $urandom_range(0, TO - 1);
      rv = {$urandom, $urandom}; wv = {$urandom, $urandom};
      donec = mis ? 1 : !ld ? 2 + rd : (wd < TO) ? 3 + rd + wd : 2 + rd + TO;
      exp_err = mis || (ld && wd >= TO);
      exp_rd = (ld && !mis && wd < TO) ? rv : 64'h0;
      for (int c = 0; c <= donec + 1; c++) begin
        @(negedge clk);
        start = (c == 0) || (c <= donec && $urandom_range(0, 3) == 0);
        if (c == 0) begin is_load = ld; base = b; imm9 = i; wdata = wv; end
        else begin is_load = 1'($urandom); base = {$urandom, $urandom}; imm9 = 9'($urandom); wdata = {$urandom, $urandom}; end
        mem_req_ready = (c >= 1 + rd);
        inw = ld && !mis && c >= 2 + rd && c < donec;
        mem_rsp_valid = inw ? (c == 2 + rd + wd) : 1'($urandom);
        mem_rdata = (inw && c == 2 + rd + wd) ? rv : {$urandom, $urandom};
        #1;
        checks++; if ({done, stall, mem_req_valid} !== {c == donec, c < donec, !mis && c >= 1 && c <= 1 + rd}) begin errors++; $display("FAIL rand_ctl n%0d c%0d: got %b done@%0d", n, c, {done, stall, mem_req_valid}, donec); end
        if (!mis && c >= 1 && c <= 1 + rd) begin
          checks++; if ({mem_addr, mem_we, mem_wdata} !== {a, !ld, wv}) begin errors++; $display("FAIL rand_req n%0d c%0d: got %h %b %h exp %h %b %h", n, c, mem_addr, mem_we, mem_wdata, a, !ld, wv); end
        end
        if (c == donec) begin
          checks++; if ({err, rdata} !== {exp_err, exp_rd}) begin errors++; $display("FAIL rand_done n%0d: got %b %h exp %b %h", n, err, rdata, exp_err, exp_rd); end
        end
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; is_load = 0; base = '0; imm9 = '0; wdata = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_store();
    test_load_handshake();
    test_misaligned();
    test_timeout();
    test_reset_abort();
    test_wrap_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
